// File: rtl/lfsr_batch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_batch_pkg
//  Description : Register offsets, CTRL/STATUS bit positions and FSM state
//                encoding shared by the LFSR batch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_batch_pkg;

    // Word offsets inside the 0x20-byte register window
    localparam logic [4:0] c_off_ctrl     = 5'h00;
    localparam logic [4:0] c_off_status   = 5'h04;
    localparam logic [4:0] c_off_seed     = 5'h08;
    localparam logic [4:0] c_off_count    = 5'h0C;
    localparam logic [4:0] c_off_result   = 5'h10;
    localparam logic [4:0] c_off_done_cnt = 5'h14;

    // CTRL bits
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_abort = 1;
    localparam int c_ctrl_chain = 2;

    // STATUS bits; FIFO level occupies [15:8]
    localparam int c_st_running = 0;
    localparam int c_st_empty   = 1;
    localparam int c_st_full    = 2;
    localparam int c_st_ovf     = 3;
    localparam int c_st_unf     = 4;
    localparam int c_st_tmo     = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_STORE     = 3'd4,
        ST_STALL     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_batch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_batch_ctrl_if
//  Description : MemSplit32-style split bus between the UDM master and the
//                LFSR batch controller register window.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_batch_ctrl_if;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [31:0] bus_addr_bi;
    logic [3:0]  bus_be_bi;
    logic [31:0] bus_wdata_bi;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;

    modport master (
        output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
        input  bus_ack_o, bus_resp_o, bus_rdata_bo
    );

    modport slave (
        input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
        output bus_ack_o, bus_resp_o, bus_rdata_bo
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_batch_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO with level output and a
//                synchronous flush. Push when full / pop when empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_POW = 4
) (
    input  wire                  clk_i,
    input  wire                  rst_n_i,
    input  wire                  flush_i,
    input  wire                  push_i,
    input  wire                  pop_i,
    input  wire  [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DEPTH_POW:0]   level_o
);
    localparam int                 c_depth_int = 2 ** DEPTH_POW;
    localparam int                 c_lw        = DEPTH_POW + 1;
    localparam logic [c_lw-1:0]    c_depth     = c_lw'(c_depth_int);

    logic [WIDTH-1:0]     mem_q [c_depth_int];
    logic [DEPTH_POW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_POW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0]      level_q, level_d;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full_o    = (level_q == c_depth);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign w_do_push = push_i & ~full_o & ~flush_i;
    assign w_do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointer and level update; flush empties the FIFO regardless of push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + DEPTH_POW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_POW'(1);
            level_d = level_q + c_lw'(w_do_push) - c_lw'(w_do_pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility
    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule
`default_nettype wire

// File: rtl/lfsr_batch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_batch_ctrl
//  Description : Memory-mapped sequencer that runs an LFSR core COUNT times
//                from a programmed seed and queues the results in a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_batch_ctrl
    import lfsr_batch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
    parameter int          FIFO_DEPTH_POW = 4,
    parameter int          BUSY_WAIT_MAX  = 16
) (
    input  wire                 clk_i,
    input  wire                 rst_n_i,
    lfsr_batch_ctrl_if.slave    bus,
    output logic [31:0]         core_seed_o,
    output logic                core_start_o,
    output logic                core_rst_o,
    input  wire                 core_busy_i,
    input  wire  [31:0]         core_result_i
);
    localparam int              c_lw        = FIFO_DEPTH_POW + 1;
    localparam logic [c_lw-1:0] c_depth     = c_lw'(2 ** FIFO_DEPTH_POW);
    localparam logic [15:0]     c_wait_last = 16'(BUSY_WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [31:0] seed_q, seed_d;
    logic [15:0] count_q, count_d;
    logic [31:0] seed_cur_q, seed_cur_d;
    logic        chain_q, chain_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [31:0] result_q, result_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        ovf_err_q, ovf_err_d;
    logic        unf_err_q, unf_err_d;
    logic        tmo_err_q, tmo_err_d;
    logic [1:0]  abort_cnt_q, abort_cnt_d;
    logic        resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;

    logic            w_sel, w_acc, w_wr, w_rd, w_ctrl_wr, w_abort, w_start;
    logic            w_pop_req, w_pop, w_push, w_full, w_empty;
    logic [4:0]      w_off;
    logic [c_lw-1:0] w_level, w_level_after;
    logic [31:0]     w_fifo_rdata, w_rdata;
    logic [3:0]      w_unused_be;

    // Address decode: the window is BASE_ADDR .. BASE_ADDR+0x1F
    assign w_sel     = (bus.bus_addr_bi >= BASE_ADDR) && (bus.bus_addr_bi < BASE_ADDR + 32'h20);
    assign w_off     = bus.bus_addr_bi[4:0] - BASE_ADDR[4:0];
    assign w_acc     = bus.bus_req_i & w_sel;
    assign w_wr      = w_acc & bus.bus_we_i;
    assign w_rd      = w_acc & ~bus.bus_we_i;
    assign w_ctrl_wr = w_wr && (w_off == c_off_ctrl);
    assign w_abort   = w_ctrl_wr & bus.bus_wdata_bi[c_ctrl_abort];
    assign w_start   = w_ctrl_wr & bus.bus_wdata_bi[c_ctrl_start] & ~bus.bus_wdata_bi[c_ctrl_abort]
                       & (count_q != 16'd0);
    assign w_pop_req = w_rd && (w_off == c_off_result);
    assign w_pop     = w_pop_req & ~w_empty;
    assign w_level_after = w_level + c_lw'(1) - c_lw'(w_pop);
    assign w_unused_be   = bus.bus_be_bi;

    assign bus.bus_ack_o    = w_acc;
    assign bus.bus_resp_o   = resp_q;
    assign bus.bus_rdata_bo = rdata_q;
    assign core_seed_o      = seed_cur_q;
    assign core_start_o     = (state_q == ST_LOAD);
    assign core_rst_o       = ~rst_n_i | (abort_cnt_q != 2'd0);

    sync_fifo #(
        .WIDTH     (32),
        .DEPTH_POW (FIFO_DEPTH_POW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (w_abort),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (result_q),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

    // Read mux; values are sampled on the accepting edge and presented next cycle
    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            c_off_status: begin
                w_rdata[c_st_running] = (state_q != ST_IDLE);
                w_rdata[c_st_empty]   = w_empty;
                w_rdata[c_st_full]    = w_full;
                w_rdata[c_st_ovf]     = ovf_err_q;
                w_rdata[c_st_unf]     = unf_err_q;
                w_rdata[c_st_tmo]     = tmo_err_q;
                w_rdata[15:8]         = 8'(w_level);
            end
            c_off_seed:     w_rdata = seed_q;
            c_off_count:    w_rdata = {16'h0, count_q};
            c_off_result:   w_rdata = w_empty ? 32'h0 : w_fifo_rdata;
            c_off_done_cnt: w_rdata = {16'h0, done_cnt_q};
            default:        w_rdata = 32'h0;
        endcase
    end

    // Sequencer FSM, register writes and error tracking
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        count_d     = count_q;
        seed_cur_d  = seed_cur_q;
        chain_d     = chain_q;
        remaining_d = remaining_q;
        done_cnt_d  = done_cnt_q;
        result_d    = result_q;
        wait_cnt_d  = wait_cnt_q;
        ovf_err_d   = ovf_err_q;
        unf_err_d   = unf_err_q;
        tmo_err_d   = tmo_err_q;
        abort_cnt_d = (abort_cnt_q != 2'd0) ? abort_cnt_q - 2'd1 : 2'd0;
        w_push      = 1'b0;
        resp_d      = w_rd;
        rdata_d     = w_rd ? w_rdata : 32'h0;

        if (w_wr && (w_off == c_off_seed))  seed_d  = bus.bus_wdata_bi;
        if (w_wr && (w_off == c_off_count)) count_d = bus.bus_wdata_bi[15:0];
        if (w_pop_req && w_empty)           unf_err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    done_cnt_d  = 16'd0;
                    ovf_err_d   = 1'b0;
                    unf_err_d   = 1'b0;
                    tmo_err_d   = 1'b0;
                    remaining_d = count_q;
                    seed_cur_d  = seed_q;
                    chain_d     = bus.bus_wdata_bi[c_ctrl_chain];
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wait_cnt_d = 16'd0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (core_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (wait_cnt_q == c_wait_last) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!core_busy_i) begin
                    result_d = core_result_i;
                    state_d  = ST_STORE;
                end
            end
            ST_STORE: begin
                // STALL normally prevents a full FIFO here; flag it if it happens
                if (w_full) ovf_err_d = 1'b1;
                else        w_push    = 1'b1;
                done_cnt_d  = done_cnt_q + 16'd1;
                remaining_d = remaining_q - 16'd1;
                if (chain_q) seed_cur_d = result_q;
                if (remaining_q == 16'd1)                      state_d = ST_IDLE;
                else if (!w_full && (w_level_after == c_depth)) state_d = ST_STALL;
                else                                            state_d = ST_LOAD;
            end
            ST_STALL: begin
                if (!w_full) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // ABORT overrides everything, including a START in the same write
        if (w_abort) begin
            state_d     = ST_IDLE;
            w_push      = 1'b0;
            abort_cnt_d = 2'd2;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            seed_q      <= 32'h0;
            count_q     <= 16'h0;
            seed_cur_q  <= 32'h0;
            chain_q     <= 1'b0;
            remaining_q <= 16'h0;
            done_cnt_q  <= 16'h0;
            result_q    <= 32'h0;
            wait_cnt_q  <= 16'h0;
            ovf_err_q   <= 1'b0;
            unf_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            abort_cnt_q <= 2'd0;
            resp_q      <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            count_q     <= count_d;
            seed_cur_q  <= seed_cur_d;
            chain_q     <= chain_d;
            remaining_q <= remaining_d;
            done_cnt_q  <= done_cnt_d;
            result_q    <= result_d;
            wait_cnt_q  <= wait_cnt_d;
            ovf_err_q   <= ovf_err_d;
            unf_err_q   <= unf_err_d;
            tmo_err_q   <= tmo_err_d;
            abort_cnt_q <= abort_cnt_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lfsr_batch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_batch_ctrl
//  Description : Self-checking bench for lfsr_batch_ctrl with a behavioural
//                LFSR core model and a result/seed reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_batch_ctrl;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_SEED = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_RES  = BASE + 32'h10;
    localparam logic [31:0] A_DONE = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] core_seed;
    logic        core_start, core_rst, core_busy;
    logic [31:0] core_result = 32'h0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lfsr_batch_ctrl_if bus_if ();

    lfsr_batch_ctrl #(
        .BASE_ADDR      (BASE),
        .FIFO_DEPTH_POW (2),
        .BUSY_WAIT_MAX  (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .bus           (bus_if),
        .core_seed_o   (core_seed),
        .core_start_o  (core_start),
        .core_rst_o    (core_rst),
        .core_busy_i   (core_busy),
        .core_result_i (core_result)
    );

    // Reference LFSR: eight Galois steps with taps 0x80200003
    function automatic logic [31:0] lfsr(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int k = 0; k < 8; k++) v = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
        return v;
    endfunction

    // Expected seeds and results of a batch
    task automatic model_batch(input logic [31:0] seed, input int n, input bit chain,
                               output logic [31:0] seeds[$], output logic [31:0] res[$]);
        logic [31:0] s;
        s = seed;
        seeds = {};
        res = {};
        for (int i = 0; i < n; i++) begin
            seeds.push_back(s);
            res.push_back(lfsr(s));
            if (chain) s = lfsr(s);
        end
    endtask

    // Core model: busy for 4 cycles after a start, or never when never_busy
    int          busy_left = 0;
    bit          never_busy = 1'b0;
    assign core_busy = (busy_left != 0);
    always @(posedge clk) begin
        if (core_rst) busy_left <= 0;
        else if (core_start && !never_busy) begin
            busy_left   <= 4;
            core_result <= lfsr(core_seed);
        end else if (busy_left > 0) busy_left <= busy_left - 1;
    end

    // Observers for start pulses and core reset cycles
    logic [31:0] seen_seeds[$];
    int          start_cnt = 0;
    int          rst_hi = 0;
    always @(posedge clk) if (core_start) begin
        seen_seeds.push_back(core_seed);
        start_cnt <= start_cnt + 1;
    end
    always @(negedge clk) if (core_rst) rst_hi <= rst_hi + 1;

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.bus_req_i = 1'b1; bus_if.bus_we_i = 1'b1;
        bus_if.bus_addr_bi = addr; bus_if.bus_wdata_bi = data;
        @(posedge clk); #1;
        bus_if.bus_req_i = 1'b0; bus_if.bus_we_i = 1'b0;
    endtask

    // Returns the read data, whether it was acked, and whether resp/rdata
    // followed the one-cycle-later protocol
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic acked, output logic resp_ok);
        @(negedge clk);
        bus_if.bus_req_i = 1'b1; bus_if.bus_we_i = 1'b0; bus_if.bus_addr_bi = addr;
        #1;
        acked   = bus_if.bus_ack_o;
        resp_ok = (bus_if.bus_resp_o === 1'b0);
        @(posedge clk); #1;
        bus_if.bus_req_i = 1'b0;
        resp_ok = resp_ok && (bus_if.bus_resp_o === 1'b1);
        data    = bus_if.bus_rdata_bo;
        @(posedge clk); #1;
        resp_ok = resp_ok && (bus_if.bus_resp_o === 1'b0) && (bus_if.bus_rdata_bo === 32'h0);
    endtask

    task automatic wait_idle(output bit ok);
        logic [31:0] d; logic a, r;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_read(A_STAT, d, a, r);
            if (d[0] == 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_level(input int lvl, output bit ok);
        logic [31:0] d; logic a, r;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_read(A_STAT, d, a, r);
            if (int'(d[15:8]) >= lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic a, r;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
        checks++; if ({bus_if.bus_ack_o, bus_if.bus_resp_o, core_start} !== 3'b000 || bus_if.bus_rdata_bo !== 32'h0 || core_seed !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: ack/resp/start %b%b%b rdata %h seed %h expected all 0",
                               bus_if.bus_ack_o, bus_if.bus_resp_o, core_start, bus_if.bus_rdata_bo, core_seed);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL reset_core_rst_release: got %b expected 0", core_rst); end
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", d); end
        checks++; if (a !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL reset_read_timing: ack %b resp_ok %b expected 1 1", a, r); end
        bus_read(A_DONE, d, a, r);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_done_cnt: got %h expected 0", d); end
        bus_read(A_SEED, d, a, r);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_seed: got %h expected 0", d); end
    endtask

    // Runs one batch that fits in the FIFO and checks seeds, level, count and data
    task automatic test_batch(input string name, input logic [31:0] seed, input int n, input bit chain);
        logic [31:0] d; logic a, r; bit ok; int base;
        logic [31:0] es[$]; logic [31:0] er[$];
        model_batch(seed, n, chain, es, er);
        base = seen_seeds.size();
        bus_write(A_SEED, seed);
        bus_write(A_CNT, 32'(n));
        bus_write(A_CTRL, chain ? 32'h5 : 32'h1);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: batch still running", name); end
        checks++; if (seen_seeds.size() - base !== n) begin errors++; $display("FAIL %s_starts: got %0d expected %0d", name, seen_seeds.size() - base, n); end
        for (int i = 0; i < n && base + i < seen_seeds.size(); i++) begin
            checks++; if (seen_seeds[base + i] !== es[i]) begin errors++; $display("FAIL %s_seed%0d: got %h expected %h", name, i, seen_seeds[base + i], es[i]); end
        end
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== ({16'h0, 8'(n), 8'h0} | (n == 4 ? 32'h4 : 32'h0))) begin errors++; $display("FAIL %s_status: got %h level expected %0d", name, d, n); end
        bus_read(A_DONE, d, a, r);
        checks++; if (d !== 32'(n)) begin errors++; $display("FAIL %s_done_cnt: got %h expected %0d", name, d, n); end
        for (int i = 0; i < n; i++) begin
            bus_read(A_RES, d, a, r);
            checks++; if (d !== er[i] || r !== 1'b1) begin errors++; $display("FAIL %s_result%0d: got %h resp_ok %b expected %h", name, i, d, r, er[i]); end
        end
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL %s_drained: got %h expected 00000002", name, d); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++)
            test_batch("random", $urandom, int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)));
    endtask

    task automatic test_stall();
        logic [31:0] d; logic a, r; bit ok; bit chain;
        logic [31:0] es[$]; logic [31:0] er[$]; logic [31:0] seed;
        seed  = $urandom;
        chain = bit'($urandom_range(0, 1));
        model_batch(seed, 6, chain, es, er);
        bus_write(A_SEED, seed);
        bus_write(A_CNT, 32'd6);
        bus_write(A_CTRL, chain ? 32'h5 : 32'h1);
        wait_level(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_fill: FIFO never reached 4"); end
        repeat (30) @(posedge clk);
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h405) begin errors++; $display("FAIL stall_status: got %h expected 00000405", d); end
        for (int i = 0; i < 2; i++) begin
            bus_read(A_RES, d, a, r);
            checks++; if (d !== er[i]) begin errors++; $display("FAIL stall_pop%0d: got %h expected %h", i, d, er[i]); end
        end
        wait_idle(ok);
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h404) begin errors++; $display("FAIL stall_final_status: got %h expected 00000404", d); end
        bus_read(A_DONE, d, a, r);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL stall_done_cnt: got %h expected 6", d); end
        for (int i = 2; i < 6; i++) begin
            bus_read(A_RES, d, a, r);
            checks++; if (d !== er[i]) begin errors++; $display("FAIL stall_result%0d: got %h expected %h", i, d, er[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic a, r;
        never_busy = 1'b1;
        bus_write(A_CNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        repeat (40) @(posedge clk);
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h22) begin errors++; $display("FAIL timeout_status: got %h expected 00000022", d); end
        bus_read(A_RES, d, a, r);
        checks++; if (d !== 32'h0 || r !== 1'b1) begin errors++; $display("FAIL underflow_rdata: got %h resp_ok %b expected 0 1", d, r); end
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h32) begin errors++; $display("FAIL underflow_status: got %h expected 00000032", d); end
        never_busy = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] d; logic a, r; bit ok; int rst0, st0;
        bus_write(A_SEED, $urandom);
        bus_write(A_CNT, 32'd8);
        bus_write(A_CTRL, 32'h1);
        wait_level(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_fill: no result before abort"); end
        rst0 = rst_hi;
        bus_write(A_CTRL, 32'h3);
        st0 = start_cnt;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (rst_hi - rst0 !== 2) begin errors++; $display("FAIL abort_core_rst: high %0d cycles expected 2", rst_hi - rst0); end
        checks++; if (start_cnt !== st0) begin errors++; $display("FAIL abort_no_start: got %0d starts expected 0", start_cnt - st0); end
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL abort_status: got %h expected 00000002", d); end
        bus_read(A_DONE, d, a, r);
        checks++; if (d === 32'h0) begin errors++; $display("FAIL abort_done_kept: got %h expected nonzero", d); end
    endtask

    task automatic test_window();
        logic [31:0] d; logic a, r;
        bus_read(32'h0000_0200, d, a, r);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL oow_ack_200: got %b expected 0", a); end
        bus_read(BASE + 32'h20, d, a, r);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL oow_ack_top: got %b expected 0", a); end
        bus_read(BASE - 32'h4, d, a, r);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL oow_ack_below: got %b expected 0", a); end
        bus_read(BASE + 32'h1C, d, a, r);
        checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_read: ack %b data %h expected 1 0", a, d); end
        bus_write(A_SEED, 32'h1234_5678);
        bus_write(32'h0000_0208, 32'hDEAD_BEEF);
        bus_write(A_STAT, 32'hFFFF_FFFF);
        bus_read(A_SEED, d, a, r);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL seed_rw: got %h expected 12345678", d); end
        bus_read(A_STAT, d, a, r);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL status_ro: got %h expected 00000002", d); end
    endtask

    initial begin
        bus_if.bus_req_i = 1'b0; bus_if.bus_we_i = 1'b0; bus_if.bus_addr_bi = 32'h0;
        bus_if.bus_be_bi = 4'hF; bus_if.bus_wdata_bi = 32'h0;
        test_reset();
        test_batch("basic", 32'h0000_ACE1, 3, 1'b0);
        test_batch("chain", 32'h0000_0001, 2, 1'b1);
        test_random();
        test_stall();
        test_timeout();
        test_abort();
        test_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
